// File: rtl/ci_shift_pipe.sv
// ci_shift_pipe: pipelined Nios II multicycle custom-instruction barrel shifter.
// Five shift/rotate modes selected by n; the log2 barrel levels are spread
// over LATENCY register stages, and the whole pipe freezes while clk_en is low.
module ci_shift_pipe #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              start,
    input  logic [DATA_W-1:0] dataa,
    input  logic [DATA_W-1:0] datab,
    input  logic [2:0]        n,
    output logic [DATA_W-1:0] result,
    output logic              done
);

    localparam int unsigned SH_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        MODE_SLL = 3'd0,
        MODE_SRL = 3'd1,
        MODE_SRA = 3'd2,
        MODE_ROL = 3'd3,
        MODE_ROR = 3'd4
    } mode_e;

    // Per-stage registers; the last stage's data register is the result.
    logic [LATENCY-1:0][DATA_W-1:0] q_data;
    logic [LATENCY-1:0][SH_W-1:0]   q_amt;
    logic [LATENCY-1:0][2:0]        q_mode;
    logic [LATENCY-1:0]             q_sign;
    logic [LATENCY-1:0]             q_valid;

    logic [LATENCY-1:0][DATA_W-1:0] nxt_data;
    logic [LATENCY-1:0][SH_W-1:0]   nxt_amt;
    logic [LATENCY-1:0][2:0]        nxt_mode;
    logic [LATENCY-1:0]             nxt_sign;
    logic [LATENCY-1:0]             nxt_valid;

    logic [DATA_W-1:0] c_data;
    logic [SH_W-1:0]   c_amt;
    logic [2:0]        c_mode;
    logic              c_sign;
    logic              c_valid;

    // Upper shift-amount bits and the trailing copies of amount/mode/sign are
    // carried for uniformity but never consumed.
    logic pipe_unused;
    assign pipe_unused = ^{datab[DATA_W-1:SH_W], q_amt[LATENCY-1],
                           q_mode[LATENCY-1], q_sign[LATENCY-1]};

    // One barrel level: shift/rotate d by the constant distance k (1 <= k < DATA_W).
    function automatic logic [DATA_W-1:0] shift_step(
        input logic [DATA_W-1:0] d,
        input logic [2:0]        m,
        input logic              sgn,
        input int unsigned       k
    );
        logic [2*DATA_W-1:0] ext;
        ext        = {{DATA_W{sgn}}, d} >> k;
        shift_step = d;
        case (m)
            MODE_SLL: shift_step = d << k;
            MODE_SRL: shift_step = d >> k;
            MODE_SRA: shift_step = ext[DATA_W-1:0];
            MODE_ROL: shift_step = (d << k) | (d >> (DATA_W - k));
            MODE_ROR: shift_step = (d >> k) | (d << (DATA_W - k));
            default:  shift_step = d;
        endcase
    endfunction

    // Next-state of every stage: take the previous stage (or the ports for
    // stage 0) and apply the barrel levels assigned to this stage. Level l
    // goes to stage (l*LATENCY)/SH_W, so levels are spread evenly and the
    // final value does not depend on LATENCY. Unsupported modes are zeroed on
    // entry and then pass through every level untouched.
    always_comb begin
        c_data    = '0;
        c_amt     = '0;
        c_mode    = '0;
        c_sign    = 1'b0;
        c_valid   = 1'b0;
        nxt_data  = '0;
        nxt_amt   = '0;
        nxt_mode  = '0;
        nxt_sign  = '0;
        nxt_valid = '0;
        for (int unsigned s = 0; s < LATENCY; s++) begin
            if (s == 0) begin
                c_valid = start;
                c_data  = (n > 3'd4) ? '0 : dataa;
                c_amt   = datab[SH_W-1:0];
                c_mode  = n;
                c_sign  = dataa[DATA_W-1];
            end else begin
                c_valid = q_valid[s-1];
                c_data  = q_data[s-1];
                c_amt   = q_amt[s-1];
                c_mode  = q_mode[s-1];
                c_sign  = q_sign[s-1];
            end
            for (int unsigned l = 0; l < SH_W; l++) begin
                if (((l * LATENCY) / SH_W) == s && c_amt[l]) begin
                    c_data = shift_step(c_data, c_mode, c_sign, 32'd1 << l);
                end
            end
            nxt_valid[s] = c_valid;
            nxt_data[s]  = c_data;
            nxt_amt[s]   = c_amt;
            nxt_mode[s]  = c_mode;
            nxt_sign[s]  = c_sign;
        end
    end

    // Advance the pipe only when enabled; payload registers load only for
    // valid operations so bubbles never disturb the held result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_valid <= '0;
            q_data  <= '0;
            q_amt   <= '0;
            q_mode  <= '0;
            q_sign  <= '0;
        end else if (clk_en) begin
            q_valid <= nxt_valid;
            for (int unsigned s = 0; s < LATENCY; s++) begin
                if (nxt_valid[s]) begin
                    q_data[s] <= nxt_data[s];
                    q_amt[s]  <= nxt_amt[s];
                    q_mode[s] <= nxt_mode[s];
                    q_sign[s] <= nxt_sign[s];
                end
            end
        end
    end

    assign result = q_data[LATENCY-1];
    assign done   = q_valid[LATENCY-1] & clk_en;

endmodule

// File: tb/tb_ci_shift_pipe.sv
// tb_ci_shift_pipe: four shifter configurations driven in lockstep and checked
// every cycle against a bit-level reference model and a completion scoreboard.
module tb_ci_shift_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic        start;
    logic [2:0]  n;
    logic [63:0] dataa;
    logic [63:0] datab;

    logic [31:0] r0;
    logic [15:0] r1;
    logic [63:0] r2;
    logic [31:0] r3;
    logic        d0, d1, d2, d3;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          inst;
        logic [63:0] val;
        int          due;
    } op_t;

    op_t         pend[$];
    int          en_cnt;
    logic [63:0] last_res [4];

    always #5 clk = ~clk;

    ci_shift_pipe #(.DATA_W(32), .LATENCY(2)) u_w32_l2 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
        .dataa(dataa[31:0]), .datab(datab[31:0]), .n(n), .result(r0), .done(d0));
    ci_shift_pipe #(.DATA_W(16), .LATENCY(1)) u_w16_l1 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
        .dataa(dataa[15:0]), .datab(datab[15:0]), .n(n), .result(r1), .done(d1));
    ci_shift_pipe #(.DATA_W(64), .LATENCY(8)) u_w64_l8 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
        .dataa(dataa), .datab(datab), .n(n), .result(r2), .done(d2));
    ci_shift_pipe #(.DATA_W(32), .LATENCY(4)) u_w32_l4 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
        .dataa(dataa[31:0]), .datab(datab[31:0]), .n(n), .result(r3), .done(d3));

    function automatic int wid(input int i);
        case (i)
            0: return 32;
            1: return 16;
            2: return 64;
            default: return 32;
        endcase
    endfunction

    function automatic int lat(input int i);
        case (i)
            0: return 2;
            1: return 1;
            2: return 8;
            default: return 4;
        endcase
    endfunction

    function automatic logic [63:0] obs_res(input int i);
        case (i)
            0: return {32'b0, r0};
            1: return {48'b0, r1};
            2: return r2;
            default: return {32'b0, r3};
        endcase
    endfunction

    function automatic logic obs_done(input int i);
        case (i)
            0: return d0;
            1: return d1;
            2: return d2;
            default: return d3;
        endcase
    endfunction

    // Reference: each output bit i picks its source bit directly.
    function automatic logic [63:0] ref_shift(input int w, input logic [63:0] a,
                                              input logic [63:0] b, input logic [2:0] m);
        logic [63:0] r;
        int          s;
        logic        sg;
        r  = '0;
        s  = int'(b[5:0]) % w;
        sg = a[w-1];
        if (m > 3'd4) return '0;
        for (int i = 0; i < w; i++) begin
            case (m)
                3'd0: r[i] = (i >= s) ? a[i-s] : 1'b0;
                3'd1: r[i] = (i + s < w) ? a[i+s] : 1'b0;
                3'd2: r[i] = (i + s < w) ? a[i+s] : sg;
                3'd3: r[i] = a[(i - s + w) % w];
                default: r[i] = a[(i + s) % w];
            endcase
        end
        return r;
    endfunction

    task automatic chk(input string tag, input int inst, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s inst=%0d observed=%h expected=%h", tag, inst, obs, exp);
        end
    endtask

    task automatic model_clear();
        pend.delete();
        for (int i = 0; i < 4; i++) last_res[i] = '0;
    endtask

    // Scoreboard update for one rising edge, using the inputs present at it.
    task automatic model_update();
        op_t keep[$];
        if (reset) begin
            model_clear();
        end else if (clk_en) begin
            en_cnt++;
            foreach (pend[k]) if (pend[k].due >= en_cnt) keep.push_back(pend[k]);
            pend = keep;
            if (start) begin
                for (int i = 0; i < 4; i++) begin
                    op_t o;
                    o.inst = i;
                    o.val  = ref_shift(wid(i), dataa, datab, n);
                    o.due  = en_cnt + lat(i) - 1;
                    pend.push_back(o);
                end
            end
            foreach (pend[k]) if (pend[k].due == en_cnt) last_res[pend[k].inst] = pend[k].val;
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 4; i++) begin
            logic ed;
            ed = 1'b0;
            if (clk_en && !reset)
                foreach (pend[k]) if (pend[k].inst == i && pend[k].due == en_cnt) ed = 1'b1;
            chk({tag, "_done"}, i, {63'b0, obs_done(i)}, {63'b0, ed});
            chk({tag, "_result"}, i, obs_res(i), last_res[i]);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic op(input string tag, input logic [63:0] a, input logic [63:0] b,
                      input logic [2:0] m);
        start = 1'b1;
        dataa = a;
        datab = b;
        n     = m;
        step(tag);
        start = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        clk_en = 1'b1;
        start  = 1'b0;
        n      = 3'd0;
        dataa  = '0;
        datab  = '0;
        en_cnt = 0;
        model_clear();

        step("reset");
        step("reset");
        reset = 1'b0;
        step("idle");

        // Five modes on the same operand, separated by idle cycles.
        for (int m = 0; m < 5; m++) begin
            op("mode", 64'h0000_0000_8000_0001, 64'd4, 3'(m));
            step("mode_gap");
            step("mode_gap");
        end

        // Amount masking, zero amount, unsupported mode, SRA sign fill.
        op("mask", 64'h0000_0000_FFFF_0000, 64'h0000_0000_0000_0024, 3'd1);
        for (int m = 0; m < 5; m++) op("amt0", 64'hA5A5_1234_5A5A_C3C3, 64'd0, 3'(m));
        op("mode6", 64'hDEAD_BEEF_CAFE_F00D, 64'd3, 3'd6);
        op("sra_max", 64'h8000_0000_8000_8000, 64'd31, 3'd2);
        op("sra_max", 64'h8000_0000_8000_8000, 64'd63, 3'd2);
        repeat (10) step("drain");

        // Back-to-back rotates.
        for (int k = 1; k <= 4; k++) op("b2b", 64'd1, 64'(k), 3'd3);
        repeat (10) step("b2b_drain");

        // Stall while in flight; a start during the stall must be ignored.
        op("stall_op", 64'h0000_0000_1234_5678, 64'd8, 3'd3);
        clk_en = 1'b0;
        start  = 1'b1;
        dataa  = 64'hFFFF_FFFF_FFFF_FFFF;
        datab  = 64'd1;
        n      = 3'd0;
        repeat (3) step("stall");
        start  = 1'b0;
        clk_en = 1'b1;
        repeat (10) step("stall_resume");

        // Asynchronous reset one cycle after a start.
        op("rst_op", 64'h0000_0000_0F0F_0F0F, 64'd5, 3'd4);
        step("rst_wait");
        reset = 1'b1;
        #1;
        model_clear();
        check_all("async_rst");
        #1;
        reset = 1'b0;
        repeat (10) step("post_rst");

        // Randomised traffic with random stalls.
        for (int c = 0; c < 400; c++) begin
            clk_en = ($urandom_range(0, 4) != 0);
            start  = ($urandom_range(0, 2) != 0);
            dataa  = {$urandom, $urandom};
            datab  = {$urandom, $urandom};
            n      = 3'($urandom_range(0, 7));
            step("rand");
        end
        start  = 1'b0;
        clk_en = 1'b1;
        repeat (12) step("rand_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ci_shift_pipe.md
Name: ci_shift_pipe

Overview:
- Parametrised, fully pipelined Nios II multicycle custom-instruction barrel shifter.
- Replaces the fixed 32-bit single-function shift custom instruction.
- Adds selectable width, selectable latency and five shift/rotate modes chosen by the custom-instruction `n` field.
- Uses an in-order valid pipeline that freezes on `clk_en` low instead of losing its count.

Parameters:
- DATA_W, 32, operand/result width; power of two, 8..64.
- LATENCY, 2, cycles from accepted start to done; 1..8.
- SH_W, $clog2(DATA_W), shift-amount width (derived; not overridden).

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- clk_en  input  1  Nios custom-instruction clock enable; low = stall.
- start  input  1  operation request; sampled only when clk_en=1.
- dataa  input  DATA_W  value to shift.
- datab  input  DATA_W  shift amount; only datab[SH_W-1:0] is used.
- n  input  3  mode select.
- result  output  DATA_W  registered shift result.
- done  output  1  completion strobe, one per accepted start.

Behaviour:
- Reset is asynchronous and active-high. Reset values: result=0, done=0; all pipeline valid bits, operands and mode registers are cleared.
- Accept: an operation is accepted on a rising edge where start=1 and clk_en=1. dataa, datab[SH_W-1:0] and n are captured on that edge.
- Modes:
  - n=0 SLL: logical left, zero fill.
  - n=1 SRL: logical right, zero fill.
  - n=2 SRA: arithmetic right, sign fill from dataa[DATA_W-1].
  - n=3 ROL: rotate left.
  - n=4 ROR: rotate right.
  - n=5..7: result=0; done is still produced.
- Shift amount is taken modulo DATA_W (upper datab bits ignored). An amount of 0 returns dataa unchanged in every mode. An amount of DATA_W-1 in SRA returns all sign bits.
- Latency: if start is accepted at edge k and clk_en stays high, then result and done=1 are presented in the cycle following edge k+LATENCY-1. For LATENCY=1, done appears the cycle immediately after start.
- Pipeline depth is LATENCY registers. The barrel levels may be split across stages in any way, provided the numeric result is identical for every LATENCY.
- Throughput: one accept per cycle. Back-to-back starts complete in order, each with its own single-cycle done pulse.
- done = last-stage valid AND clk_en. done is never high while clk_en=0.
- Stall (clk_en=0):
  - all pipeline registers, valid bits and result hold;
  - start is ignored;
  - when clk_en returns high, the pipeline resumes where it stopped, so completion slips by exactly the stall length.
- result holds the most recently completed value until the next completion. It does not update for invalid (bubble) stages.
- Reset asserted mid-operation discards all in-flight operations. No done occurs after release until a new start is accepted.
- No internal counter wraps. A valid shift register carries completions, so no count can underflow (no state_sync-style decrement).

Test Plan:
- DATA_W=32, LATENCY=2: start with dataa=0x80000001, datab=4, n=0..4 in separate ops -> results 0x00000010, 0x08000000, 0xF8000000, 0x00000018, 0x18000000; done exactly 2 cycles after each start.
- datab=0x00000024 (amount masked to 4), n=1, dataa=0xFFFF0000 -> result 0x0FFFF000. Amount 0 in all modes -> result = dataa. n=6 -> result 0, done asserted.
- Four back-to-back starts (ROL by 1,2,3,4 of 0x00000001) -> four consecutive done cycles with results 0x2, 0x4, 0x8, 0x10 in order.
- Start accepted, then clk_en low for 3 cycles while in flight -> done stays 0 during the stall and arrives 3 cycles late with the correct result. A start asserted during the stall produces no completion.
- reset pulsed 1 cycle after start (LATENCY=4) -> result=0, done=0 immediately (asynchronous). No done for 10 following cycles without a new start.
- Repeat directed vectors with DATA_W=16/LATENCY=1 and DATA_W=64/LATENCY=8 -> results match the reference model; done latency equals LATENCY.
